// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_FRAME_BITS = 10;
  localparam logic LINE_IDLE       = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags the
// final cycle of each bit period.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic rd_clk,
  input  logic rd_rst,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_tick = run && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Read-side FIFO consumer that pops bytes and sends them as UART 8N1 frames,
// entirely in the FIFO read-clock domain.
//
// state | meaning
// IDLE  | line high, waiting for tx_en with a non-empty FIFO
// FETCH | one-cycle pop strobe to the FIFO
// LATCH | FIFO read data valid; load shift register, clear baud timer
// START | start bit (line low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high); may chain straight into FETCH
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              i_tx_en,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_rd_en,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_byte_done
);

  if (DATA_W != UART_DATA_BITS) begin : g_bad_data_w
    $error("fifo_uart_tx: DATA_W must be 8 for 8N1 framing");
  end
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be within 2..65535");
  end

  tx_state_e         state, state_nxt;
  logic [DATA_W-1:0] shift;
  logic [2:0]        bit_idx;
  logic              bit_tick;
  logic              baud_run;
  logic              baud_clear;

  assign baud_run   = (state == START) || (state == DATA) || (state == STOP);
  assign baud_clear = (state == LATCH);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .clear   (baud_clear),
    .run     (baud_run),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // bit_idx wraps 7->0 on its own as the last data bit completes.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        LATCH: begin
          shift   <= i_rd_data;
          bit_idx <= '0;
        end
        DATA: begin
          if (bit_tick) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_tx_en && !i_fifo_empty) state_nxt = FETCH;
      FETCH: state_nxt = LATCH;
      LATCH: state_nxt = START;
      START: if (bit_tick) state_nxt = DATA;
      DATA:  if (bit_tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP: begin
        if (bit_tick) begin
          state_nxt = (i_tx_en && !i_fifo_empty) ? FETCH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode only registered state, so no input reaches an output directly.
  always_comb begin
    o_tx        = LINE_IDLE;
    o_rd_en     = 1'b0;
    o_busy      = (state != IDLE);
    o_byte_done = 1'b0;
    case (state)
      FETCH: o_rd_en = 1'b1;
      START: o_tx = 1'b0;
      DATA:  o_tx = shift[0];
      STOP:  o_byte_done = bit_tick;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a registered-read
// FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] rd_data = 8'h00;
  logic       rd_en;
  logic       tx;
  logic       busy;
  logic       byte_done;

  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;

  int tests = 0;
  int fails = 0;
  int rd_en_cnt = 0;
  int done_cnt = 0;
  int bad_pop = 0;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W(8)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .i_tx_en     (tx_en),
    .i_fifo_empty(fifo_empty),
    .i_rd_data   (rd_data),
    .o_rd_en     (rd_en),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_byte_done (byte_done)
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 4'd1;
    end
  end

  always @(posedge rd_clk) begin
    if (rd_en === 1'b1) rd_en_cnt <= rd_en_cnt + 1;
    if (byte_done === 1'b1) done_cnt <= done_cnt + 1;
    if (rd_en === 1'b1 && fifo_empty) bad_pop <= bad_pop + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] want, input int want_wait,
                           input int drop_at);
    int         waited;
    logic [39:0] line_v;
    logic [39:0] done_v;
    logic        busy_all;
    logic [9:0]  fbits;
    logic [7:0]  rx;
    waited   = 0;
    line_v   = '0;
    done_v   = '0;
    busy_all = 1'b1;
    fbits    = {1'b1, want, 1'b0};
    rx       = '0;
    while (tx !== 1'b0 && waited < 200) begin
      step();
      waited++;
    end
    check({tag, " start_wait"}, 64'(waited), 64'(want_wait));
    if (waited >= 200) return;
    for (int k = 0; k < 40; k++) begin
      line_v[k] = tx;
      done_v[k] = byte_done;
      busy_all  = busy_all & busy;
      if (k == drop_at) tx_en = 1'b0;
      if (k < 39) step();
    end
    for (int b = 0; b < 10; b++) begin
      check($sformatf("%s bit%0d", tag, b), 64'(line_v[4*b +: 4]), 64'({4{fbits[b]}}));
    end
    for (int b = 0; b < 8; b++) rx[b] = line_v[4*(b+1) + 2];
    check({tag, " byte"}, 64'(rx), 64'(want));
    check({tag, " byte_done_pos"}, 64'(done_v), 64'(40'h80_0000_0000));
    check({tag, " busy_in_frame"}, 64'(busy_all), 64'(1'b1));
  endtask

  initial begin
    rd_rst = 1'b1;
    tx_en  = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // 1: reset held with a non-empty FIFO
    mem[0] = 8'h34;
    wr_ptr = 4'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("reset c%0d tx/rd_en/busy/done", i), 64'({tx, rd_en, busy, byte_done}),
            64'(4'b1000));
    end
    check("reset no pop", 64'(rd_en_cnt), 64'd0);

    // 2: single byte, starts 3 cycles after IDLE sees non-empty
    rd_rst = 1'b0;
    run_frame("single34", 8'h34, 3, -1);
    step();
    check("single busy_after", 64'({busy, tx}), 64'(2'b01));
    check("single rd_en_cnt", 64'(rd_en_cnt), 64'd1);
    check("single done_cnt", 64'(done_cnt), 64'd1);

    // 3: five back-to-back bytes
    mem[1] = 8'h34; mem[2] = 8'hA8; mem[3] = 8'h0F; mem[4] = 8'hAB; mem[5] = 8'h09;
    wr_ptr = 4'd6;
    run_frame("burst0", 8'h34, 3, -1);
    run_frame("burst1", 8'hA8, 3, -1);
    run_frame("burst2", 8'h0F, 3, -1);
    run_frame("burst3", 8'hAB, 3, -1);
    run_frame("burst4", 8'h09, 3, -1);
    step();
    check("burst busy_after", 64'(busy), 64'd0);
    check("burst rd_en_cnt", 64'(rd_en_cnt), 64'd6);
    check("burst done_cnt", 64'(done_cnt), 64'd6);

    // 4: empty FIFO with tx_en high
    for (int i = 0; i < 100; i++) begin
      step();
      check($sformatf("empty c%0d tx/rd_en/busy", i), 64'({tx, rd_en, busy}), 64'(3'b100));
    end
    check("empty rd_en_cnt", 64'(rd_en_cnt), 64'd6);

    // 5: tx_en dropped during data bit 3 of 0xA8 (frame bit 4 = samples 16..19)
    mem[6] = 8'hA8; mem[7] = 8'h0F;
    wr_ptr = 4'd8;
    run_frame("drop A8", 8'hA8, 3, 17);
    for (int i = 0; i < 20; i++) step();
    check("drop rd_en_cnt", 64'(rd_en_cnt), 64'd7);
    check("drop idle tx/busy", 64'({tx, busy}), 64'(2'b10));
    tx_en = 1'b1;
    run_frame("resume 0F", 8'h0F, 3, -1);
    step();
    check("resume rd_en_cnt", 64'(rd_en_cnt), 64'd8);

    // 6: reset in the middle of 0xAB's data bits
    mem[8] = 8'hAB; mem[9] = 8'h09;
    wr_ptr = 4'd10;
    begin
      int waited;
      waited = 0;
      while (tx !== 1'b0 && waited < 200) begin
        step();
        waited++;
      end
      check("abort start_wait", 64'(waited), 64'd3);
    end
    for (int i = 0; i < 12; i++) step();
    check("abort pre busy", 64'(busy), 64'd1);
    rd_rst = 1'b1;
    step();
    check("abort tx/busy", 64'({tx, busy, rd_en}), 64'(3'b100));
    rd_rst = 1'b0;
    run_frame("after_rst 09", 8'h09, 3, -1);
    for (int i = 0; i < 30; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) break;
    end
    check("no resend tx/busy", 64'({tx, busy}), 64'(2'b10));
    check("final rd_en_cnt", 64'(rd_en_cnt), 64'd10);
    check("final done_cnt", 64'(done_cnt), 64'd9);
    check("no underflow pop", 64'(bad_pop), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the async byte FIFO, living entirely in the FIFO's read-clock domain.
- Pops one byte whenever the FIFO is non-empty and transmission is enabled.
- Serialises each byte as a UART 8N1 frame on o_tx: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Drives the FIFO's rd_en and consumes its rd_data and empty flag; no other CDC logic inside.

Parameters:
- CLKS_PER_BIT, 16, rd_clk cycles per UART bit; legal range 2..65535.
- DATA_W, 8, byte width; fixed at 8 for 8N1 and checked at elaboration.

Ports:
- rd_clk  input  1  sole clock; the FIFO read clock.
- rd_rst  input  1  reset, synchronous, active-high.
- i_tx_en  input  1  1 = block may fetch new bytes; 0 = finish the current frame, then hold in IDLE.
- i_fifo_empty  input  1  FIFO empty flag, from o_fifo_empty.
- i_rd_data  input  8  FIFO read data; valid the cycle after an o_rd_en cycle (registered read).
- o_rd_en  output  1  FIFO pop strobe, to rd_en.
- o_tx  output  1  serial line; idle high.
- o_busy  output  1  high in every state except IDLE.
- o_byte_done  output  1  one-cycle pulse on the final cycle of each stop bit.

Behaviour:
- Reset: while rd_rst is sampled high, the state machine goes to IDLE and the following values take effect on the next rd_clk edge:
  - o_tx=1, o_rd_en=0, o_busy=0, o_byte_done=0.
  - Bit counter, baud counter and shift register all cleared to 0.
  - Reset mid-frame aborts the frame; no FIFO pop is issued, and any byte already popped is lost.
- All outputs are registered or decoded from registered state; nothing is combinational from the inputs to the outputs.
- States: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE: if i_tx_en=1 and i_fifo_empty=0, go to FETCH; otherwise stay.
- FETCH: exactly one cycle; o_rd_en=1; next state LATCH.
- LATCH: one cycle; capture i_rd_data into the shift register; clear the baud counter; next state START.
- START: o_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: o_tx = shift[0] for CLKS_PER_BIT cycles, then shift right. After bit index 7 completes, go to STOP.
- STOP: o_tx=1 for CLKS_PER_BIT cycles. o_byte_done=1 on the last of those cycles. Then:
  - if i_tx_en=1 and i_fifo_empty=0 (sampled on that last cycle), go to FETCH;
  - otherwise go to IDLE.
- Latency: o_tx falls 3 rd_clk cycles after the edge on which IDLE samples empty=0 with tx_en=1.
- Frame timing:
  - a frame occupies exactly 10*CLKS_PER_BIT cycles of o_tx;
  - back-to-back frames are separated by exactly 2 idle-high cycles (FETCH + LATCH).
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit index: 3 bits, wraps 7→0 on the transition into STOP.
- o_rd_en is never asserted while i_fifo_empty=1. Empty is sampled only in IDLE and in the last STOP cycle, so an underflow pop is impossible.
- i_tx_en deasserted mid-frame: the current frame completes unchanged; no further pop occurs.
- i_fifo_empty toggling in START, DATA or STOP is ignored.
- o_busy is 1 from FETCH through the last STOP cycle inclusive.

Decomposition:
- Package fifo_uart_pkg holds:
  - the state enum (IDLE, FETCH, LATCH, START, DATA, STOP);
  - the constants UART_DATA_BITS=8, UART_FRAME_BITS=10 and LINE_IDLE=1'b1.
- One natural sub-module, uart_baud_counter:
  - parameter CLKS_PER_BIT;
  - inputs clear and run;
  - output bit_tick, a pulse on the last cycle of each bit period;
  - reset on rd_rst.

Test Plan (all scenarios use CLKS_PER_BIT=4; the bench models the FIFO with a registered read):
1. Reset: hold rd_rst=1 for 5 cycles with FIFO non-empty → o_tx=1, o_rd_en=0, o_busy=0 throughout, and no pop.
2. Single byte 0x34, tx_en=1:
   - exactly one o_rd_en pulse;
   - o_tx per 4-cycle bit reads 0,0,0,1,0,1,1,0,0,1 (start, LSB-first 0x34, stop);
   - o_byte_done pulses once, at cycle 40 of the frame;
   - o_busy then falls.
3. Five bytes 0x34, 0xA8, 0x0F, 0xAB, 0x09 preloaded:
   - five frames decode to those values in order;
   - exactly 2 idle-high cycles between frames;
   - five rd_en pulses; o_byte_done count = 5.
4. Empty FIFO, tx_en=1, for 100 cycles → o_rd_en never asserts, o_tx=1, o_busy=0.
5. tx_en dropped during bit 3 of byte 0xA8 with the FIFO still holding 0x0F:
   - 0xA8 completes fully;
   - no further rd_en;
   - re-raising tx_en sends 0x0F with the 3-cycle start latency.
6. rd_rst asserted mid-DATA of 0xAB → o_tx=1 and o_busy=0 on the next edge; after release, the next byte 0x09 transmits correctly, and 0xAB is not resent.
